// File: rtl/sampq_pkg.sv
// Shared definitions for the sample-queue scheduler: state encoding, sample
// width and the index-width helper used by the scheduler and its arbiter.
package sampq_pkg;

  localparam int unsigned SAMPLE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Width of a source index; a single source still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sampq_rrarb.sv
// Combinational rotating-priority finder.
// Ports:
//   req         - request mask, one bit per source
//   ptr         - source with highest priority this cycle
//   grant_valid - at least one request is set
//   grant_idx   - first requesting source searching ptr, ptr+1, ... mod N
module sampq_rrarb #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] cand;

  // Walk the N candidate positions starting at ptr; the first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sampq_sched.sv
// Round-robin scheduler sharing the sample-queue write port between
// NUM_SOURCES producers.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   enable        - request queue capture (level)
//   sources       - sample words, source i at [i*32 +: 32]
//   avails        - per-source strobe: sources[i] valid this cycle
//   sample        - word presented to the queue
//   sample_valid  - sample holds a word
//   sample_ready  - queue accepts the word this cycle
//   active        - high in RUN or DRAIN
//   ovf_count     - saturating count of overwritten samples
//   ovf_mask      - sticky per-source overwrite flags
module sampq_sched
  import sampq_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [SAMPLE_W*NUM_SOURCES-1:0] sources,
  input  logic [NUM_SOURCES-1:0]          avails,
  output logic [SAMPLE_W-1:0]             sample,
  output logic                            sample_valid,
  input  logic                            sample_ready,
  output logic                            active,
  output logic [CNT_WIDTH-1:0]            ovf_count,
  output logic [NUM_SOURCES-1:0]          ovf_mask
);

  localparam int unsigned IDX_W = idx_w(NUM_SOURCES);

  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] held_q, held_d;
  logic [SAMPLE_W-1:0]    hold_q [NUM_SOURCES];
  logic [SAMPLE_W-1:0]    hold_d [NUM_SOURCES];
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [SAMPLE_W-1:0]    sample_q, sample_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   active_q, active_d;
  logic [CNT_WIDTH-1:0]   ovf_count_q, ovf_count_d;
  logic [NUM_SOURCES-1:0] ovf_mask_q, ovf_mask_d;

  logic                   load;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;

  sampq_rrarb #(
    .N     (NUM_SOURCES),
    .IDX_W (IDX_W)
  ) u_rrarb (
    .req         (held_q),
    .ptr         (rr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state: sequencing, output register load, capture and overflow.
  always_comb begin
    state_d        = state_q;
    held_d         = held_q;
    hold_d         = hold_q;
    rr_d           = rr_q;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    ovf_count_d    = ovf_count_q;
    ovf_mask_d     = ovf_mask_q;

    load = !sample_valid_q || sample_ready;

    if (load) begin
      if (grant_valid) begin
        sample_d          = hold_q[grant_idx];
        sample_valid_d    = 1'b1;
        held_d[grant_idx] = 1'b0;
        rr_d              = IDX_W'((32'(grant_idx) + 1) % NUM_SOURCES);
      end else begin
        sample_valid_d = 1'b0;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_RUN;
          ovf_count_d = '0;
          ovf_mask_d  = '0;
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable)                              state_d = ST_RUN;
        else if (held_q == '0 && !sample_valid_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A re-capture on the source being granted this cycle is not an overwrite:
    // the old word leaves through the output register.
    if (state_q == ST_RUN) begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        if (avails[i]) begin
          if (held_q[i] && !(load && grant_valid && grant_idx == IDX_W'(i))) begin
            if (ovf_count_d != {CNT_WIDTH{1'b1}}) ovf_count_d = ovf_count_d + CNT_WIDTH'(1);
            ovf_mask_d[i] = 1'b1;
          end
          hold_d[i] = sources[i*SAMPLE_W +: SAMPLE_W];
          held_d[i] = 1'b1;
        end
      end
    end

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      held_q         <= '0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) hold_q[i] <= '0;
      rr_q           <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      active_q       <= 1'b0;
      ovf_count_q    <= '0;
      ovf_mask_q     <= '0;
    end else begin
      state_q        <= state_d;
      held_q         <= held_d;
      hold_q         <= hold_d;
      rr_q           <= rr_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      active_q       <= active_d;
      ovf_count_q    <= ovf_count_d;
      ovf_mask_q     <= ovf_mask_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign active       = active_q;
  assign ovf_count    = ovf_count_q;
  assign ovf_mask     = ovf_mask_q;

endmodule

// File: tb/tb_sampq_sched.sv
// Self-checking bench for sampq_sched: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_sampq_sched;

  localparam int NS    = 4;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [NS*32-1:0]  sources = '0;
  logic [NS-1:0]     avails = '0;
  logic [31:0]       sample;
  logic              sample_valid;
  logic              sample_ready = 1'b0;
  logic              active;
  logic [CW-1:0]     ovf_count;
  logic [NS-1:0]     ovf_mask;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: mode 0 idle, 1 run, 2 drain.
  int        m_mode;
  bit [NS-1:0] m_held;
  bit [31:0] m_hold [NS];
  bit [31:0] m_out;
  bit        m_valid;
  int        m_rr;
  int        m_cnt;
  bit [NS-1:0] m_mask;
  bit        m_active;

  sampq_sched #(.NUM_SOURCES(NS), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sources      (sources),
    .avails       (avails),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .active       (active),
    .ovf_count    (ovf_count),
    .ovf_mask     (ovf_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("sample", sample, m_out);
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("active", 32'(active), 32'(m_active));
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    chk("ovf_mask", 32'(ovf_mask), 32'(m_mask));
  endtask

  task automatic model_reset();
    m_mode = 0; m_held = '0; m_out = '0; m_valid = 0; m_rr = 0;
    m_cnt = 0; m_mask = '0; m_active = 0;
    for (int i = 0; i < NS; i++) m_hold[i] = '0;
  endtask

  task automatic model_step(input bit en, input bit [NS-1:0] av, input bit [NS*32-1:0] src, input bit rdy);
    bit load;
    bit gv;
    int g;
    bit [NS-1:0] old_held;
    bit old_valid;
    old_held  = m_held;
    old_valid = m_valid;
    load = !m_valid || rdy;
    gv = 0; g = 0;
    for (int k = 0; k < NS; k++)
      if (!gv && m_held[(m_rr + k) % NS]) begin gv = 1; g = (m_rr + k) % NS; end
    if (load) begin
      if (gv) begin
        m_out = m_hold[g]; m_valid = 1; m_held[g] = 0; m_rr = (g + 1) % NS;
      end else begin
        m_valid = 0;
      end
    end
    if (m_mode == 1) begin
      for (int i = 0; i < NS; i++) begin
        if (av[i]) begin
          if (old_held[i] && !(load && gv && g == i)) begin
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            m_mask[i] = 1;
          end
          m_hold[i] = src[i*32 +: 32];
          m_held[i] = 1;
        end
      end
    end
    case (m_mode)
      0: if (en) begin m_mode = 1; m_cnt = 0; m_mask = '0; end
      1: if (!en) m_mode = 2;
      default: begin
        if (en) m_mode = 1;
        else if (old_held == '0 && !old_valid) m_mode = 0;
      end
    endcase
    m_active = (m_mode != 0);
  endtask

  task automatic cyc(input bit en, input bit [NS-1:0] av, input bit rdy);
    enable = en; avails = av; sample_ready = rdy;
    model_step(en, av, sources, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [31:0] w);
    sources[i*32 +: 32] = w;
  endtask

  logic [31:0] exp_a [4];

  initial begin
    model_reset();
    do_reset();
    chk("rst_sample", sample, 32'h0);
    chk("rst_active", 32'(active), 32'h0);

    // Startup: one word, two cycles of latency, one transfer.
    set_src(0, 32'h1111_1111);
    cyc(1, 4'b0000, 1);
    chk("start_active", 32'(active), 32'h1);
    cyc(1, 4'b0001, 1);
    chk("start_lat1_valid", 32'(sample_valid), 32'h0);
    cyc(1, 4'b0000, 1);
    chk("start_valid", 32'(sample_valid), 32'h1);
    chk("start_word", sample, 32'h1111_1111);
    cyc(1, 4'b0000, 1);
    chk("start_one_xfer", 32'(sample_valid), 32'h0);

    // Fairness from rr=0, then from rr=2.
    do_reset();
    cyc(1, 4'b0000, 1);
    for (int i = 0; i < NS; i++) set_src(i, 32'hA0 + 32'(i));
    cyc(1, 4'b1111, 1);
    exp_a[0] = 32'hA0; exp_a[1] = 32'hA1; exp_a[2] = 32'hA2; exp_a[3] = 32'hA3;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 4'b0000, 1);
      chk("rr0_order", sample, exp_a[k]);
    end
    set_src(1, 32'hB1);
    cyc(1, 4'b0010, 1);
    cyc(1, 4'b0000, 1);
    chk("rr_setup_word", sample, 32'hB1);
    for (int i = 0; i < NS; i++) set_src(i, 32'hA0 + 32'(i));
    cyc(1, 4'b1111, 1);
    exp_a[0] = 32'hA2; exp_a[1] = 32'hA3; exp_a[2] = 32'hA0; exp_a[3] = 32'hA1;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 4'b0000, 1);
      chk("rr2_order", sample, exp_a[k]);
    end
    cyc(1, 4'b0000, 1);

    // Backpressure and overwrite on source 1.
    set_src(1, 32'h5); cyc(1, 4'b0010, 0);
    set_src(1, 32'h6); cyc(1, 4'b0010, 0);
    set_src(1, 32'h7); cyc(1, 4'b0010, 0);
    chk("bp_out", sample, 32'h5);
    chk("bp_cnt", 32'(ovf_count), 32'h1);
    chk("bp_mask", 32'(ovf_mask), 32'h2);
    cyc(1, 4'b0000, 1);
    chk("bp_next", sample, 32'h7);
    cyc(1, 4'b0000, 1);
    chk("bp_empty", 32'(sample_valid), 32'h0);

    // Grant and re-capture of source 0 in the same cycle.
    set_src(0, 32'h21); cyc(1, 4'b0001, 1);
    set_src(0, 32'h22); cyc(1, 4'b0001, 1);
    chk("sim_out", sample, 32'h21);
    chk("sim_no_ovf", 32'(ovf_count), 32'h1);
    cyc(1, 4'b0000, 1);
    chk("sim_new", sample, 32'h22);
    cyc(1, 4'b0000, 1);

    // Drain: strobes during DRAIN are ignored.
    set_src(2, 32'h32); set_src(3, 32'h33);
    cyc(1, 4'b1100, 0);
    cyc(0, 4'b0000, 0);
    chk("drain_first", sample, 32'h32);
    for (int i = 0; i < NS; i++) set_src(i, 32'hDEAD_0000 + 32'(i));
    cyc(0, 4'b1111, 1);
    chk("drain_second", sample, 32'h33);
    cyc(0, 4'b1111, 1);
    chk("drain_empty", 32'(sample_valid), 32'h0);
    cyc(0, 4'b0000, 1);
    chk("drain_idle", 32'(active), 32'h0);

    // Saturating counter, then reset with a word in the output register.
    cyc(1, 4'b0000, 0);
    chk("sat_clear", 32'(ovf_count), 32'h0);
    for (int k = 0; k < 4; k++) cyc(1, 4'b1111, 0);
    chk("sat_cnt", 32'(ovf_count), 32'(CMAX));
    chk("sat_mask", 32'(ovf_mask), 32'hF);
    chk("sat_valid", 32'(sample_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(sample_valid), 32'h0);
    chk("arst_sample", sample, 32'h0);
    chk("arst_cnt", 32'(ovf_count), 32'h0);
    chk("arst_mask", 32'(ovf_mask), 32'h0);
    chk("arst_active", 32'(active), 32'h0);
    do_reset();
    cyc(0, 4'b0000, 1);
    cyc(0, 4'b0000, 1);
    chk("post_rst_valid", 32'(sample_valid), 32'h0);

    // Randomized traffic against the model.
    begin
      bit en;
      en = 1;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 29) == 0) en = ~en;
        for (int i = 0; i < NS; i++) set_src(i, $urandom);
        if ($urandom_range(0, 599) == 0) do_reset();
        else cyc(en, NS'($urandom & $urandom), $urandom_range(0, 3) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
